// File: rtl/cycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the cycle sequencer:
//   - state_e       : sequencer states (RESET_WAIT encodes as 0)
//   - STG_*         : bit positions of the stage enables in the one-hot vector
//   - CNT_W_DEFAULT : default width of the cycle / instruction counters
//   - stage_onehot  : maps a state to its one-hot stage-enable vector
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

    localparam int CNT_W_DEFAULT = 32;

    localparam int STG_FETCH   = 0;
    localparam int STG_DECODE  = 1;
    localparam int STG_EXECUTE = 2;
    localparam int STG_WB      = 3;
    localparam int NUM_STG     = 4;

    typedef enum logic [2:0] {
        ST_RESET_WAIT = 3'd0,
        ST_IDLE       = 3'd1,
        ST_FETCH      = 3'd2,
        ST_DECODE     = 3'd3,
        ST_EXECUTE    = 3'd4,
        ST_WRITEBACK  = 3'd5,
        ST_HALTED     = 3'd6
    } state_e;

    // Non-stage states map to all-zero, so "running" is just the OR-reduction.
    function automatic logic [NUM_STG-1:0] stage_onehot(input state_e s);
        logic [NUM_STG-1:0] v;
        v = '0;
        case (s)
            ST_FETCH:     v[STG_FETCH]   = 1'b1;
            ST_DECODE:    v[STG_DECODE]  = 1'b1;
            ST_EXECUTE:   v[STG_EXECUTE] = 1'b1;
            ST_WRITEBACK: v[STG_WB]      = 1'b1;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cycle_sequencer_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Free-running up-counter with enable; wraps modulo 2^W.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the count
//   en_i    : increment on this clock edge
//   count_o : current count
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
// Generates one-hot FETCH/DECODE/EXECUTE/WRITEBACK enables for a multi-cycle
// core, one instruction per four (unstalled) stage cycles. Supports free-run,
// single-step, stall and a sticky halt taken at instruction boundaries.
// Ports:
//   clk, rst          : clock / asynchronous active-high reset
//   active            : free-run enable (level)
//   step_req          : run exactly one instruction from IDLE (pulse)
//   halt_req          : halt at the next instruction boundary
//   stall             : hold the current stage
//   fetch_en..wb_en   : stage enables (one-hot while running)
//   instr_done        : one-cycle pulse after WRITEBACK retires
//   running / halted  : status
//   cycle_count       : clocks spent in FETCH..WRITEBACK (wrapping)
//   instr_count       : retired instructions (wrapping)
// ---------------------------------------------------------------------------
module cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int RESET_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             stall,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             instr_done,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DLY_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RESET_DELAY - 1);

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic               halt_pend_q, halt_pend_d;
    logic               step_mode_q, step_mode_d;
    logic [NUM_STG-1:0] stage_q;
    logic               instr_done_q;
    logic               running_q;
    logic               halted_q;
    logic               in_run;
    logic               retire;

    assign in_run = state_q inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK};

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        halt_pend_d = halt_pend_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;

        // A halt request is remembered both during the post-reset wait and
        // while an instruction is in flight; it is acted on at a boundary.
        if ((state_q == ST_RESET_WAIT || in_run) && halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            ST_RESET_WAIT: begin
                if (delay_q == DLY_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (halt_pend_q || halt_req) begin
                    state_d = ST_HALTED;
                end else if (step_req) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b1;
                end else if (active) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b0;
                end
            end
            ST_FETCH:   if (!stall) state_d = ST_DECODE;
            ST_DECODE:  if (!stall) state_d = ST_EXECUTE;
            ST_EXECUTE: if (!stall) state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (!stall) begin
                    retire = 1'b1;
                    if (halt_pend_q || halt_req) begin
                        state_d = ST_HALTED;
                    end else if (step_mode_q) begin
                        state_d     = ST_IDLE;
                        step_mode_d = 1'b0;
                    end else if (active) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RESET_WAIT;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register and are clean Moore decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET_WAIT;
            delay_q      <= '0;
            halt_pend_q  <= 1'b0;
            step_mode_q  <= 1'b0;
            stage_q      <= '0;
            instr_done_q <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            halt_pend_q  <= halt_pend_d;
            step_mode_q  <= step_mode_d;
            stage_q      <= stage_onehot(state_d);
            instr_done_q <= retire;
            running_q    <= |stage_onehot(state_d);
            halted_q     <= (state_d == ST_HALTED);
        end
    end

    assign fetch_en   = stage_q[STG_FETCH];
    assign decode_en  = stage_q[STG_DECODE];
    assign exec_en    = stage_q[STG_EXECUTE];
    assign wb_en      = stage_q[STG_WB];
    assign instr_done = instr_done_q;
    assign running    = running_q;
    assign halted     = halted_q;

    wrap_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (in_run),
        .count_o (cycle_count)
    );

    wrap_counter #(.W(CNT_W)) u_instr_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (retire),
        .count_o (instr_count)
    );

endmodule

// File: tb/tb_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
// Drives two sequencer instances (32-bit and 4-bit counters) with the same
// inputs and compares every output, every cycle, against a behavioural
// model: a stage number (-1 when not running), a remaining-wait count, a
// halted flag and plain integer counters reduced modulo the counter width.
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        stall = 1'b0;

    logic        fe_a, de_a, ex_a, wb_a, dn_a, run_a, hlt_a;
    logic [31:0] cyc_a, ins_a;
    logic        fe_b, de_b, ex_b, wb_b, dn_b, run_b, hlt_b;
    logic [3:0]  cyc_b, ins_b;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int     m_stage;
    int     m_wait;
    bit     m_halted;
    bit     m_hp;
    bit     m_sm;
    bit     m_done;
    longint m_cyc;
    longint m_ins;

    always #5 clk = ~clk;

    cycle_sequencer #(.CNT_W(32), .RESET_DELAY(2)) u_dut (
        .clk(clk), .rst(rst), .active(active), .step_req(step_req),
        .halt_req(halt_req), .stall(stall),
        .fetch_en(fe_a), .decode_en(de_a), .exec_en(ex_a), .wb_en(wb_a),
        .instr_done(dn_a), .running(run_a), .halted(hlt_a),
        .cycle_count(cyc_a), .instr_count(ins_a)
    );

    cycle_sequencer #(.CNT_W(4), .RESET_DELAY(2)) u_dut4 (
        .clk(clk), .rst(rst), .active(active), .step_req(step_req),
        .halt_req(halt_req), .stall(stall),
        .fetch_en(fe_b), .decode_en(de_b), .exec_en(ex_b), .wb_en(wb_b),
        .instr_done(dn_b), .running(run_b), .halted(hlt_b),
        .cycle_count(cyc_b), .instr_count(ins_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stage  = -1;
        m_wait   = 2;
        m_halted = 1'b0;
        m_hp     = 1'b0;
        m_sm     = 1'b0;
        m_done   = 1'b0;
        m_cyc    = 0;
        m_ins    = 0;
    endtask

    // One clock of the sequencing rules, applied to the inputs seen at the edge.
    task automatic model_step(input bit a, input bit s, input bit h, input bit st);
        m_done = 1'b0;
        if (m_halted) begin
            // absorbing
        end else if (m_wait > 0) begin
            if (h) m_hp = 1'b1;
            m_wait = m_wait - 1;
        end else if (m_stage < 0) begin
            if (m_hp || h) m_halted = 1'b1;
            else if (s) begin m_stage = 0; m_sm = 1'b1; end
            else if (a) begin m_stage = 0; m_sm = 1'b0; end
        end else begin
            m_cyc = m_cyc + 1;
            if (h) m_hp = 1'b1;
            if (!st) begin
                if (m_stage < 3) begin
                    m_stage = m_stage + 1;
                end else begin
                    m_done = 1'b1;
                    m_ins  = m_ins + 1;
                    if (m_hp) begin m_halted = 1'b1; m_stage = -1; end
                    else if (m_sm) begin m_sm = 1'b0; m_stage = -1; end
                    else if (a) m_stage = 0;
                    else m_stage = -1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_fetch"},  {fe_b, fe_a}, {2{m_stage == 0}});
        chk({tag, "_decode"}, {de_b, de_a}, {2{m_stage == 1}});
        chk({tag, "_exec"},   {ex_b, ex_a}, {2{m_stage == 2}});
        chk({tag, "_wb"},     {wb_b, wb_a}, {2{m_stage == 3}});
        chk({tag, "_done"},   {dn_b, dn_a}, {2{m_done}});
        chk({tag, "_run"},    {run_b, run_a}, {2{m_stage >= 0}});
        chk({tag, "_halted"}, {hlt_b, hlt_a}, {2{m_halted}});
        chk({tag, "_cyc32"},  64'(cyc_a), m_cyc & 64'hFFFF_FFFF);
        chk({tag, "_ins32"},  64'(ins_a), m_ins & 64'hFFFF_FFFF);
        chk({tag, "_cyc4"},   64'(cyc_b), m_cyc & 64'hF);
        chk({tag, "_ins4"},   64'(ins_b), m_ins & 64'hF);
    endtask

    // Called at a falling edge; drives inputs, takes one rising edge,
    // checks 1 time unit later, returns at the next falling edge.
    task automatic tick(input string tag, input bit a, input bit s, input bit h, input bit st);
        active   = a;
        step_req = s;
        halt_req = h;
        stall    = st;
        @(posedge clk);
        model_step(a, s, h, st);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the asynchronous clear before the
    // next rising edge, then releases at the following falling edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // free-run: three instructions back-to-back, then counter wrap
        for (int i = 0; i < 3; i++) tick("fr_start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick("fr", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fr_ins_is_3", 64'(ins_a), 64'd3);
        chk("fr_cyc_is_12", 64'(cyc_a), 64'd12);
        for (int i = 0; i < 4; i++) tick("fr_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_cyc4_is_0", 64'(cyc_b), 64'd0);
        chk("wrap_ins4_is_4", 64'(ins_b), 64'd4);
        chk("wrap_cyc32_is_16", 64'(cyc_a), 64'd16);

        // single step, second step_req during DECODE ignored
        do_reset("rst_step");
        tick("st_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("st_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("st_go", 1'b0, 1'b1, 1'b0, 1'b0);
        tick("st_dec", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("st_ign", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick("st_run", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("step_ins_is_1", 64'(ins_a), 64'd1);
        chk("step_cyc_is_4", 64'(cyc_a), 64'd4);

        // stall three cycles in EXECUTE
        do_reset("rst_stall");
        tick("sl_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("sl_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("sl_go", 1'b0, 1'b1, 1'b0, 1'b0);
        tick("sl_dec", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("sl_exe", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("sl_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        tick("sl_wb", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("sl_end", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_cyc_is_7", 64'(cyc_a), 64'd7);
        chk("stall_ins_is_1", 64'(ins_a), 64'd1);

        // halt during FETCH while free-running, then inputs ignored
        do_reset("rst_halt");
        tick("h_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("h_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("h_fetch", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("h_req", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick("h_fin", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            tick("h_abs", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("halt_flag", 64'(hlt_a), 64'd1);
        chk("halt_ins_is_1", 64'(ins_a), 64'd1);

        // stall in WRITEBACK together with halt_req
        do_reset("rst_wbh");
        tick("wh_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("wh_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("wh_go", 1'b0, 1'b1, 1'b0, 1'b0);
        tick("wh_dec", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("wh_exe", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("wh_wb", 1'b0, 1'b0, 1'b0, 1'b0);
        tick("wh_sh", 1'b0, 1'b0, 1'b1, 1'b1);
        tick("wh_s", 1'b0, 1'b0, 1'b0, 1'b1);
        tick("wh_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wbh_halted", 64'(hlt_a), 64'd1);

        // reset in the middle of DECODE
        do_reset("rst_pre");
        tick("rd_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("rd_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick("rd_run", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rd_in_decode", 64'(de_a), 64'd1);
        do_reset("rst_mid_decode");
        tick("rd_rw", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("rd_rw", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("rd_again", 1'b1, 1'b0, 1'b0, 1'b0);

        // randomized traffic with periodic resets to leave HALTED
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                do_reset("rnd_rst");
            end else begin
                tick("rnd",
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 79) == 0),
                     1'($urandom_range(0, 4) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Consumes the main CPU clock from the clock generator; produces one-hot stage enables (fetch/decode/execute/writeback) for the multi-cycle core.
- Sequences one instruction per four stage cycles. Supports stall, free-run, single-step and halt.
- Keeps cycle and retired-instruction counters for the simulation trace.

Parameters:
- CNT_W, 32, width of cycle_count and instr_count.
- RESET_DELAY, 2, cycles spent in RESET_WAIT after reset deasserts before IDLE is reachable (min 1).

Ports:
- clk  input  1  main CPU clock (c1 phase of the clock generator); all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- active  input  1  level: free-run enable.
- step_req  input  1  single-cycle pulse: execute exactly one instruction.
- halt_req  input  1  pulse or level: request halt at next instruction boundary.
- stall  input  1  level: freeze the current stage.
- fetch_en  output  1  high while state = FETCH.
- decode_en  output  1  high while state = DECODE.
- exec_en  output  1  high while state = EXECUTE.
- wb_en  output  1  high while state = WRITEBACK.
- instr_done  output  1  one-cycle pulse when WRITEBACK completes (not stalled).
- running  output  1  high in FETCH..WRITEBACK.
- halted  output  1  high in HALTED.
- cycle_count  output  CNT_W  cycles spent running.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- Reset values (async, immediate):
  - state = RESET_WAIT, delay counter = 0.
  - All enables, instr_done, running and halted = 0.
  - Both counters = 0; halt_pend = 0; step_mode = 0.
- States: RESET_WAIT, IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED. Outputs are registered and decoded directly from state (Moore); exactly one stage enable is high when running, none otherwise.
- RESET_WAIT:
  - Counts RESET_DELAY clocks, then goes to IDLE.
  - Inputs are ignored here, except that halt_req sets halt_pend.
- IDLE, priority order:
  - halt_pend or halt_req → HALTED.
  - else step_req → FETCH with step_mode = 1.
  - else active → FETCH with step_mode = 0.
- FETCH → DECODE → EXECUTE → WRITEBACK, one clock each when stall = 0.
  - stall = 1 holds the state, so that stage enable stays high.
  - instr_done is not asserted while stalled.
- Leaving WRITEBACK (stall = 0):
  - instr_done pulses for 1 cycle, coincident with the transition edge; instr_count increments.
  - Next state, priority order:
    - halt_pend or halt_req → HALTED.
    - else step_mode → IDLE; step_mode clears.
    - else active → FETCH (back-to-back, no bubble).
    - else → IDLE.
- halt_req while running sets sticky halt_pend; it is honoured only at the instruction boundary, so the in-flight instruction always retires.
- HALTED is absorbing: only rst leaves it. All inputs are ignored and the counters freeze.
- step_req while running or halted is ignored (not queued).
- active deasserted mid-instruction: the instruction completes, then the sequencer goes to IDLE.
- cycle_count:
  - Increments on every clock spent in FETCH..WRITEBACK, stalled cycles included.
  - Wraps modulo 2^CNT_W, no saturation.
- instr_count wraps identically.
- rst asserted mid-instruction: immediate return to reset values; the partial instruction is not counted.
- Stall applied to WRITEBACK together with halt_req: halt_pend latches, and the halt is taken when the stall drops.

Decomposition:
- Shared package cpu_seq_pkg:
  - state enum (7 encodings, RESET_WAIT = 0).
  - Stage index constants STG_FETCH=0..STG_WB=3.
  - Default CNT_W.
- One sub-module: wrap_counter, parameterised width, with async reset, enable, and a wrapping increment. Instantiated twice (cycle and instr counters).

Test Plan:
- Reset then active=1, no stall → after RESET_DELAY=2 + 1 IDLE cycle, fetch/decode/exec/wb each high exactly 1 cycle in order; instr_done on 4th stage; after 3 instructions instr_count=3, cycle_count=12.
- step_req pulse in IDLE with active=0 → exactly one FETCH..WB sequence, instr_count=1, cycle_count=4, return to IDLE; step_req pulsed during DECODE is ignored.
- stall=1 for 3 cycles during EXECUTE → exec_en high 4 cycles, instruction takes 7 cycles, cycle_count=7, instr_count=1.
- halt_req pulse during FETCH with active=1 → current instruction retires (instr_count=1), then halted=1 and no further enables; active toggling and step_req have no effect until rst.
- rst asserted mid-DECODE → all outputs 0 asynchronously (before next clk edge), counters 0, RESET_WAIT re-entered.
- CNT_W=4, free-run → cycle_count wraps 15→0 after 16 cycles; instr_count=4 at that point.
